// File: rtl/normaliza_flt_pkg.sv
// rtl/normaliza_flt_pkg.sv - shared constants and FSM encoding for the float normaliser
package normaliza_flt_pkg;

    localparam int EXP_W   = 10;
    localparam int MANT_W  = 28;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Two guard bits keep carry/shift excursions of a 10-bit exponent from wrapping.
    localparam int EXP_IW = EXP_W + 2;

    localparam logic signed [EXP_IW-1:0] EXP_ONE   = EXP_IW'(1);
    localparam logic signed [EXP_IW-1:0] EXP_ZERO  = '0;
    localparam logic signed [EXP_IW-1:0] EXP_MAX_S = EXP_IW'(EXP_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT_L,
        ST_ROUND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/normaliza_flt_arredonda_rne.sv
// rtl/normaliza_flt_arredonda_rne.sv - combinational round-to-nearest-even of a normalised mantissa
module arredonda_rne
    import normaliza_flt_pkg::*;
(
    input  logic [MANT_W-2:0] mant,
    output logic              carry,
    output logic [22:0]       frac,
    output logic              inexact
);

    logic        lsb;
    logic        g;
    logic        st;
    logic        inc;
    logic [24:0] sum;
    logic        unused_hidden;

    assign lsb = mant[3];
    assign g   = mant[2];
    assign st  = mant[1] | mant[0];
    assign inc = g & (st | lsb);

    assign sum     = {1'b0, mant[26:3]} + {24'd0, inc};
    assign carry   = sum[24];
    assign frac    = sum[22:0];
    assign inexact = g | st;

    // Hidden bit is implied by normalisation; only the carry and fraction matter.
    assign unused_hidden = sum[23];

endmodule

// File: rtl/normaliza_flt.sv
// rtl/normaliza_flt.sv - multi-cycle normalise/round/pack of a raw mantissa into IEEE-754 single
module normaliza_flt
    import normaliza_flt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sinal_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic [31:0]       s,
    output logic              finish,
    output logic              busy,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    state_t                    state_q, state_d;
    logic                      sign_q, sign_d;
    logic signed [EXP_IW-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0]         mant_q, mant_d;
    logic [31:0]               s_q, s_d;
    logic                      finish_q, finish_d;
    logic                      ovf_q, ovf_d;
    logic                      unf_q, unf_d;
    logic                      inx_q, inx_d;

    logic                      rnd_carry;
    logic [22:0]               rnd_frac;
    logic                      rnd_inexact;
    logic signed [EXP_IW-1:0]  exp_r;

    arredonda_rne u_rne (
        .mant    (mant_q[MANT_W-2:0]),
        .carry   (rnd_carry),
        .frac    (rnd_frac),
        .inexact (rnd_inexact)
    );

    assign exp_r = exp_q + {{(EXP_IW-1){1'b0}}, rnd_carry};

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        s_d      = s_q;
        finish_d = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d  = sinal_in;
                    exp_d   = {{(EXP_IW-EXP_W){exp_in[EXP_W-1]}}, exp_in};
                    mant_d  = mant_in;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inx_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mant_q == '0) begin
                    s_d     = {sign_q, 31'b0};
                    state_d = ST_DONE;
                end else if (mant_q[27]) begin
                    // Fold the dropped bit into sticky so rounding still sees it.
                    mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = ST_ROUND;
                end else if (mant_q[26]) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_SHIFT_L;
                end
            end
            ST_SHIFT_L: begin
                mant_d = {mant_q[MANT_W-2:0], 1'b0};
                exp_d  = exp_q - EXP_ONE;
                if (mant_q[25]) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (exp_r >= EXP_MAX_S) begin
                    s_d   = {sign_q, 8'hFF, 23'b0};
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else if (exp_r <= EXP_ZERO) begin
                    s_d   = {sign_q, 31'b0};
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    s_d   = {sign_q, exp_r[7:0], rnd_frac};
                    inx_d = rnd_inexact;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                finish_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            s_q      <= '0;
            finish_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            s_q      <= s_d;
            finish_q <= finish_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    assign s         = s_q;
    assign finish    = finish_q;
    assign busy      = (state_q != ST_IDLE);
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_normaliza_flt.sv
// tb/tb_normaliza_flt.sv - scoreboard bench for normaliza_flt with arithmetic reference model
module tb_normaliza_flt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sinal_in = 1'b0;
    logic [9:0]  exp_in = '0;
    logic [27:0] mant_in = '0;
    logic [31:0] s;
    logic        finish, busy, overflow, underflow, inexact;

    normaliza_flt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sinal_in  (sinal_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .s         (s),
        .finish    (finish),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] s;
        bit          ov;
        bit          un;
        bit          ix;
        int          lat;
        int          t0;
    } item_t;

    item_t sb[$];
    item_t got;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic item_t mkc(logic [31:0] sv, bit ov, bit un, bit ix, int lat);
        item_t r;
        r.s = sv; r.ov = ov; r.un = un; r.ix = ix; r.lat = lat; r.t0 = 0;
        return r;
    endfunction

    // Reference: normalise to [1,2) with plain arithmetic, then RNE on the 3 tail bits.
    function automatic item_t model(bit sg, logic [9:0] ex, logic [27:0] mn);
        item_t  r;
        longint m = longint'(mn);
        int     e = int'($signed(ex));
        int     k = 0;
        longint frac, rem;
        r = mkc(32'h0, 0, 0, 0, 0);
        if (m == 0) begin
            r.s = {sg, 31'b0};
            r.lat = 2;
            return r;
        end
        if (m >= (longint'(1) << 27)) begin
            m = (m >> 1) | (m & 1);
            e++;
        end
        while (m < (longint'(1) << 26)) begin
            m = m * 2;
            e--;
            k++;
        end
        frac = m >> 3;
        rem  = m % 8;
        if (rem > 4 || (rem == 4 && frac % 2 == 1)) frac++;
        if (frac == (longint'(1) << 24)) begin
            frac = longint'(1) << 23;
            e++;
        end
        r.ix  = (rem != 0);
        r.lat = 3 + k;
        if (e >= 255) begin
            r.s = {sg, 8'hFF, 23'b0}; r.ov = 1; r.ix = 1;
        end else if (e <= 0) begin
            r.s = {sg, 31'b0}; r.un = 1; r.ix = 1;
        end else begin
            r.s = {sg, 8'(e), 23'(frac)};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && finish) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_finish: got finish=1 expected no pending op (t=%0t)", $time);
            end else begin
                got = sb.pop_front();
                chk("result_s", s, got.s);
                chk("overflow", overflow, got.ov);
                chk("underflow", underflow, got.un);
                chk("inexact", inexact, got.ix);
                chk("latency", cyc - got.t0 - 1, got.lat);
            end
        end
    end

    task automatic wait_idle();
        int w = 0;
        while ((busy || finish) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
        end
    endtask

    task automatic raw_start(bit sg, logic [9:0] ex, logic [27:0] mn);
        sinal_in = sg; exp_in = ex; mant_in = mn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(bit sg, logic [9:0] ex, logic [27:0] mn, item_t e);
        wait_idle();
        e.t0 = cyc;
        sb.push_back(e);
        raw_start(sg, ex, mn);
    endtask

    task automatic wait_done();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_s"}, s, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_flags"}, {overflow, underflow, inexact}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 10'd127, 28'h4000000, mkc(32'h3F800000, 0, 0, 0, 3));
        issue(0, 10'd127, 28'h8000000, mkc(32'h40000000, 0, 0, 0, 3));
        issue(0, 10'd130, 28'h0800000, mkc(32'h3F800000, 0, 0, 0, 6));
        issue(0, 10'd127, 28'h4000004, mkc(32'h3F800000, 0, 0, 1, 3));
        issue(0, 10'd127, 28'h400000C, mkc(32'h3F800002, 0, 0, 1, 3));
        issue(1, 10'd254, 28'h7FFFFFC, mkc(32'hFF800000, 1, 0, 1, 3));
        issue(0, 10'd0,   28'h4000000, mkc(32'h00000000, 0, 1, 1, 3));
        issue(1, 10'd127, 28'h0000000, mkc(32'h80000000, 0, 0, 0, 2));
        wait_done();
        repeat (3) @(negedge clk);
        chk("hold_s", s, 32'h80000000);

        // Start pulses while busy must be ignored.
        issue(0, 10'd127, 28'h0000001, mkc(32'h32800000, 0, 0, 0, 29));
        for (int i = 0; i < 12; i++) begin
            if (busy) begin
                sinal_in = 1'($urandom);
                exp_in   = 10'($urandom);
                mant_in  = 28'($urandom);
                start    = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();

        // Reset mid-operation aborts without a finish pulse.
        wait_idle();
        raw_start(0, 10'd127, 28'h0000001);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cleared("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 10'd127, 28'h4000000, mkc(32'h3F800000, 0, 0, 0, 3));
        wait_done();

        for (int i = 0; i < 150; i++) begin
            bit          sg;
            logic [9:0]  ex;
            logic [27:0] mn;
            int          p;
            sg = 1'($urandom);
            ex = (i % 10 == 0) ? 10'($urandom) : 10'($urandom_range(0, 300) - 20);
            if ($urandom_range(0, 9) == 0) begin
                mn = '0;
            end else begin
                p  = $urandom_range(0, 27);
                mn = 28'((1 << p) | ($urandom & ((1 << p) - 1)));
            end
            issue(sg, ex, mn, model(sg, ex, mn));
        end
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/normaliza_flt.md
NORMALIZA_FLT -- requirements
Module: normaliza_flt

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  in  1  one-cycle request, sampled in IDLE only.
REQ-004 SHALL have: sinal_in  in  1  result sign.
REQ-005 SHALL have: exp_in  in  10  signed two's-complement biased exponent (true exponent + 127).
REQ-006 SHALL have: mant_in  in  28  raw upstream mantissa.
  - bit27 carry (weight 2^1); bit26 hidden (2^0).
  - bits25:3 fraction; bit2 guard; bits1:0 sticky.
REQ-007 SHALL have: s  out  32  IEEE-754 single result.
REQ-008 SHALL have: finish  out  1  one-cycle done pulse.
REQ-009 SHALL have: busy  out  1  high in every state except IDLE.
REQ-010 SHALL have: overflow, underflow, inexact  out  1 each  sticky-per-operation flags, valid with finish.

Function
REQ-011 SHALL implement FSM states IDLE, CHECK, SHIFT_L, ROUND, DONE.
REQ-012 IDLE: on start=1, SHALL register sinal_in, exp_in and mant_in, clear flags, and go to CHECK; start in any other state SHALL be ignored.
REQ-013 CHECK: if mant=0, SHALL form signed zero {sign,31'b0} and go to DONE with all flags 0.
REQ-014 CHECK: if mant[27]=1, SHALL shift right 1 (new bit0 = old bit1|bit0), exp+1, and go to ROUND.
REQ-015 CHECK: elif mant[26]=1, SHALL go to ROUND; else SHALL go to SHIFT_L.
REQ-016 SHIFT_L: SHALL shift mant left 1 per cycle, exp-1 per cycle, and go to ROUND in the cycle mant[26] becomes 1; at most 26 iterations.
REQ-017 ROUND: SHALL round to nearest, ties to even: lsb=mant[3], g=mant[2], st=mant[1]|mant[0], inc=g&(st|lsb).
REQ-018 ROUND: SHALL compute the 25-bit sum mant[26:3]+inc; on carry-out, mantissa SHALL become 1.0 and exp+1.
REQ-019 ROUND: inexact SHALL equal g|st.
REQ-020 ROUND: final exp>=255 SHALL give s={sign,8'hFF,23'b0}, overflow=1, inexact=1.
REQ-021 ROUND: final exp<=0 SHALL give s={sign,31'b0}, underflow=1, inexact=1 (no subnormals).
REQ-022 ROUND: otherwise s SHALL be {sign,exp[7:0],sum[22:0]}; s SHALL be registered on exit from ROUND.
REQ-023 DONE: SHALL assert finish for exactly one cycle, then go to IDLE.
REQ-024 s and flags SHALL hold their value from DONE until the next accepted start.
REQ-025 Latency: finish SHALL be high 3 cycles after the start edge, +k cycles for k left shifts; zero input SHALL take 2 cycles.
REQ-026 Exponent arithmetic SHALL be 10-bit signed with no wrap; range checks SHALL be signed.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, s=0, finish=0, busy=0, all flags 0 and all internal registers to 0.
REQ-028 Reset mid-operation SHALL abort without a finish pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-029 Shared package normaliza_flt_pkg SHALL hold FSM state encoding, BIAS=127, EXP_MAX=255, and widths EXP_W=10, MANT_W=28.
REQ-030 Rounding (REQ-017..019) SHALL be a combinational sub-module arredonda_rne; FSM, shifter and exception logic SHALL reside in normaliza_flt.

Verification
REQ-031 mant=0x4000000, exp=127, sign=0 -> s=0x3F800000, finish at cycle 3, all flags 0.
REQ-032 Carry case: mant=0x8000000, exp=127 -> s=0x40000000, cycle 3; left-shift case: mant=0x0800000, exp=130 -> s=0x3F800000, finish at cycle 6.
REQ-033 RNE: mant=0x4000004, exp=127 -> 0x3F800000, inexact=1; mant=0x400000C -> 0x3F800002, inexact=1.
REQ-034 Overflow via round carry: mant=0x7FFFFFC, exp=254, sign=1 -> s=0xFF800000, overflow=1; underflow: mant=0x4000000, exp=0 -> 0x00000000, underflow=1.
REQ-035 Zero: mant=0, sign=1 -> 0x80000000 at cycle 2; start pulses while busy=1 SHALL not change the result.
REQ-036 Reset: mant=0x0000001, exp=127, drop rst_n 5 cycles after start -> no finish, s=0, busy=0; a new start with mant=0x4000000, exp=127 then yields 0x3F800000.
